// File: rtl/pc_fetch_control.sv
// Fetch-side program counter sequencer: warm-up delay, in-order issue gated by
// unit availability, and branch/forced redirects followed by a short flush.
//
// state  | meaning
// WARMUP | post-reset delay, no issue, redirects ignored
// RUN    | issue one address per cycle when all units accept and not stalled
// FLUSH  | bubble cycles after a redirect, no issue
module pc_fetch_control #(
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           NUM_UNITS      = 5,
    parameter int unsigned           STARTUP_CYCLES = 100,
    parameter int unsigned           FLUSH_CYCLES   = 1,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
    parameter logic [ADDR_WIDTH-1:0] STEP           = {{(ADDR_WIDTH-1){1'b0}}, 1'b1},
    parameter logic [6:0]            BNE_OP         = 7'b1100011
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic [NUM_UNITS-1:0]  unitEmpty,
    input  logic                  stall,
    input  logic [6:0]            operatorType,
    input  logic                  jump,
    input  logic [ADDR_WIDTH-1:0] jumppc,
    input  logic                  pcChange,
    input  logic [ADDR_WIDTH-1:0] changeData,
    output logic                  available,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  decodePulse,
    output logic [15:0]           redirectCount,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        RUN    = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    localparam logic [15:0] WARM_LOAD  = 16'(STARTUP_CYCLES);
    localparam logic [3:0]  FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  pulse_q, pulse_d;
    logic                  avail_q, avail_d;
    logic [15:0]           redir_q, redir_d;
    logic [15:0]           warm_q, warm_d;
    logic [3:0]            flush_q, flush_d;

    logic                  can_issue;
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] target;

    assign can_issue = (&unitEmpty) & ~stall;
    assign redirect  = pcChange | (jump && (operatorType == BNE_OP));
    assign target    = pcChange ? changeData : jumppc;

    // Counters leave their state on the edge that brings them to zero, so the
    // first issue lands STARTUP_CYCLES+1 edges after reset release.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pulse_d = 1'b0;
        avail_d = avail_q;
        redir_d = redir_q;
        warm_d  = warm_q;
        flush_d = flush_q;
        case (state_q)
            WARMUP: begin
                if (warm_q <= 16'd1) state_d = RUN;
                if (warm_q != 16'd0) warm_d = warm_q - 16'd1;
            end
            RUN, FLUSH: begin
                avail_d = can_issue;
                if (redirect) begin
                    pc_d = target - STEP;
                    if (redir_q != 16'hFFFF) redir_d = redir_q + 16'd1;
                    if (FLUSH_LOAD == 4'd0) begin
                        state_d = RUN;
                    end else begin
                        state_d = FLUSH;
                        flush_d = FLUSH_LOAD;
                    end
                end else if (state_q == RUN) begin
                    if (can_issue) begin
                        pc_d    = pc_q + STEP;
                        pulse_d = 1'b1;
                    end
                end else begin
                    if (flush_q <= 4'd1) state_d = RUN;
                    if (flush_q != 4'd0) flush_d = flush_q - 4'd1;
                end
            end
            default: begin
                state_d = WARMUP;
                warm_d  = WARM_LOAD;
                flush_d = FLUSH_LOAD;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= WARMUP;
            pc_q    <= RESET_PC - STEP;
            pulse_q <= 1'b0;
            avail_q <= 1'b0;
            redir_q <= 16'd0;
            warm_q  <= WARM_LOAD;
            flush_q <= FLUSH_LOAD;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pulse_q <= pulse_d;
            avail_q <= avail_d;
            redir_q <= redir_d;
            warm_q  <= warm_d;
            flush_q <= flush_d;
        end
    end

    assign available     = avail_q;
    assign pc            = pc_q;
    assign decodePulse   = pulse_q;
    assign redirectCount = redir_q;
    assign state         = state_q;

endmodule

// File: tb/tb_pc_fetch_control.sv
// Scoreboarded bench for pc_fetch_control at default parameters: expected
// issue addresses are queued with the stimulus and matched on decodePulse.
module tb_pc_fetch_control;

    localparam logic [6:0] BNE  = 7'b1100011;
    localparam logic [6:0] ALU  = 7'b0110011;

    logic        clock = 1'b0;
    logic        resetN;
    logic [4:0]  unitEmpty;
    logic        stall;
    logic [6:0]  operatorType;
    logic        jump;
    logic [31:0] jumppc;
    logic        pcChange;
    logic [31:0] changeData;
    logic        available;
    logic [31:0] pc;
    logic        decodePulse;
    logic [15:0] redirectCount;
    logic [1:0]  state;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];

    pc_fetch_control dut (
        .clock(clock), .resetN(resetN), .unitEmpty(unitEmpty), .stall(stall),
        .operatorType(operatorType), .jump(jump), .jumppc(jumppc),
        .pcChange(pcChange), .changeData(changeData), .available(available),
        .pc(pc), .decodePulse(decodePulse), .redirectCount(redirectCount),
        .state(state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic observe();
        logic [31:0] e;
        if (decodePulse === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("issue_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("issue_pc", pc, e);
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        observe();
    endtask

    task automatic clear_redirect();
        pcChange = 1'b0; jump = 1'b0; operatorType = ALU;
        jumppc = '0; changeData = '0;
    endtask

    initial begin
        resetN = 1'b0; unitEmpty = 5'b11111; stall = 1'b0;
        clear_redirect();
        #12;
        check("rst_state", 32'(state), 32'd0);
        check("rst_pc", pc, 32'hFFFFFFFF);
        check("rst_avail", 32'(available), 32'd0);
        check("rst_pulse", 32'(decodePulse), 32'd0);
        check("rst_redir", 32'(redirectCount), 32'd0);
        @(negedge clock);
        resetN = 1'b1;

        // warm-up then sequential issue 0,1,2,3
        for (int i = 1; i <= 104; i++) begin
            if (i >= 101) exp_q.push_back(32'(i - 101));
            step();
            if (i == 99)  check("warm_state_99", 32'(state), 32'd0);
            if (i == 100) check("run_state_100", 32'(state), 32'd1);
            if (i == 100) check("avail_100", 32'(available), 32'd0);
            if (i == 101) check("avail_101", 32'(available), 32'd1);
        end
        check("drain_startup", 32'(exp_q.size()), 32'd0);

        // one unit busy for three cycles, then a stall cycle
        unitEmpty = 5'b11011;
        for (int i = 0; i < 3; i++) begin
            step();
            check("busy_pulse", 32'(decodePulse), 32'd0);
        end
        check("busy_pc", pc, 32'd3);
        check("busy_avail", 32'(available), 32'd0);
        unitEmpty = 5'b11111;
        exp_q.push_back(32'd4);
        step();
        stall = 1'b1;
        step();
        check("stall_pc", pc, 32'd4);
        stall = 1'b0;
        exp_q.push_back(32'd5);
        step();

        // jump with non-branch opcode is ignored
        jump = 1'b1; jumppc = 32'h80; operatorType = ALU;
        exp_q.push_back(32'd6);
        step();
        check("nobr_redir", 32'(redirectCount), 32'd0);
        clear_redirect();

        // pcChange beats a taken branch and beats the issue
        pcChange = 1'b1; changeData = 32'h40;
        jump = 1'b1; operatorType = BNE; jumppc = 32'h80;
        step();
        check("pcc_state", 32'(state), 32'd2);
        check("pcc_pc", pc, 32'h3F);
        check("pcc_pulse", 32'(decodePulse), 32'd0);
        check("pcc_redir", 32'(redirectCount), 32'd1);
        clear_redirect();
        step();
        check("pcc_flush_end", 32'(state), 32'd1);
        exp_q.push_back(32'h40);
        step();
        exp_q.push_back(32'h41);
        step();

        // taken branch
        jump = 1'b1; operatorType = BNE; jumppc = 32'h80;
        step();
        check("br_redir", 32'(redirectCount), 32'd2);
        clear_redirect();
        step();
        exp_q.push_back(32'h80);
        step();

        // redirect to 0 leaves pc at all-ones, next issue wraps to 0
        pcChange = 1'b1; changeData = 32'h0;
        step();
        clear_redirect();
        step();
        check("wrap_pc_pre", pc, 32'hFFFFFFFF);
        exp_q.push_back(32'h0);
        step();
        check("wrap_redir", 32'(redirectCount), 32'd3);

        // second redirect while flushing reloads the flush
        pcChange = 1'b1; changeData = 32'h100;
        step();
        changeData = 32'h200;
        step();
        check("reflush_state", 32'(state), 32'd2);
        check("reflush_pc", pc, 32'h1FF);
        check("reflush_redir", 32'(redirectCount), 32'd5);
        clear_redirect();
        step();
        exp_q.push_back(32'h200);
        step();
        check("drain_run", 32'(exp_q.size()), 32'd0);

        // asynchronous reset in the middle of a flush
        pcChange = 1'b1; changeData = 32'h300;
        step();
        check("pre_rst_state", 32'(state), 32'd2);
        clear_redirect();
        #2;
        resetN = 1'b0;
        #1;
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_pc", pc, 32'hFFFFFFFF);
        check("midrst_redir", 32'(redirectCount), 32'd0);
        check("midrst_avail", 32'(available), 32'd0);
        check("midrst_pulse", 32'(decodePulse), 32'd0);
        @(negedge clock);
        resetN = 1'b1;

        // redirects during warm-up are ignored
        pcChange = 1'b1; changeData = 32'h40;
        jump = 1'b1; operatorType = BNE; jumppc = 32'h80;
        for (int i = 0; i < 3; i++) step();
        check("warm_redir", 32'(redirectCount), 32'd0);
        check("warm_pc", pc, 32'hFFFFFFFF);
        check("warm_state", 32'(state), 32'd0);
        clear_redirect();
        check("drain_end", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
